// File: rtl/read_command_arbiter_rr_pkg.sv
// Shared types for the PULL read-command arbiter: response-demux stamp,
// arbiter FSM states and the outstanding-read credit budget.
package read_command_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    INV_EDGE_ARRAY_DEST = 2'd0,
    READ_GRAPH_DATA     = 2'd1,
    STRUCT_INVALID      = 2'd2
  } array_struct_type;

  typedef enum logic [1:0] {
    ARB_RESET = 2'd0,
    ARB_IDLE  = 2'd1,
    ARB_RUN   = 2'd2,
    ARB_DRAIN = 2'd3
  } arbiter_state_type;

  localparam int READ_CMD_CREDITS = 16;

  function automatic array_struct_type struct_of(
    input logic idx
  );
    return idx ? READ_GRAPH_DATA
               : INV_EDGE_ARRAY_DEST;
  endfunction

endpackage

// File: rtl/read_command_arbiter_rr_if.sv
// Request/command/response bundle of the read-command arbiter.
// slave = arbiter side, master = requesters + command FIFO + response path.
interface read_command_arbiter_rr_if
  import read_command_arbiter_rr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int SIZE_WIDTH   = 32,
  parameter int CREDIT_WIDTH = 5
);

  logic                    enable_in;
  logic [1:0]              req_valid_in;
  logic [ADDR_WIDTH-1:0]   req_address_in [2];
  logic [SIZE_WIDTH-1:0]   req_size_in [2];
  logic [1:0]              req_ready_out;
  logic                    cmd_ready_in;
  logic                    cmd_valid_out;
  logic [ADDR_WIDTH-1:0]   cmd_address_out;
  logic [SIZE_WIDTH-1:0]   cmd_size_out;
  array_struct_type        cmd_struct_out;
  logic                    rsp_done_in;
  logic [CREDIT_WIDTH-1:0] credits_out;
  logic                    drained_out;

  modport slave (
    input  enable_in,
    input  req_valid_in,
    input  req_address_in,
    input  req_size_in,
    input  cmd_ready_in,
    input  rsp_done_in,
    output req_ready_out,
    output cmd_valid_out,
    output cmd_address_out,
    output cmd_size_out,
    output cmd_struct_out,
    output credits_out,
    output drained_out
  );

  modport master (
    output enable_in,
    output req_valid_in,
    output req_address_in,
    output req_size_in,
    output cmd_ready_in,
    output rsp_done_in,
    input  req_ready_out,
    input  cmd_valid_out,
    input  cmd_address_out,
    input  cmd_size_out,
    input  cmd_struct_out,
    input  credits_out,
    input  drained_out
  );

endinterface

// File: rtl/read_command_arbiter_rr_round_robin_priority_arbiter_2x1.sv
// Two-way round-robin grant: prefers the requester after last_grant,
// falls back to the other one. Ports: valid[1:0], last_grant -> grant (1-hot).
module round_robin_priority_arbiter_2x1 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid[0] && (last_grant || !valid[1])):
        grant = 2'b01;
      (valid[1] && (!last_grant || !valid[0])):
        grant = 2'b10;
      default: ;
    endcase
  end

endmodule

// File: rtl/read_command_arbiter_rr.sv
// Shares one read-command channel between two PULL requesters with
// round-robin, credit-limited issue and an enable/drain handshake.
module read_command_arbiter_rr
  import read_command_arbiter_rr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 64,
  parameter int SIZE_WIDTH   = 32,
  parameter int CREDITS      = READ_CMD_CREDITS,
  parameter int CREDIT_WIDTH = 5
) (
  input logic                      clock,
  input logic                      rstn,
  read_command_arbiter_rr_if.slave bus
);

  localparam logic [CREDIT_WIDTH-1:0] CRED_FULL =
    CREDIT_WIDTH'(CREDITS);

  arbiter_state_type       state;
  logic [1:0]              buf_valid;
  logic [1:0]              buf_valid_nxt;
  logic [ADDR_WIDTH-1:0]   buf_addr [2];
  logic [SIZE_WIDTH-1:0]   buf_size [2];
  logic [1:0]              ready_q;
  logic [1:0]              load;
  logic [1:0]              grant;
  logic                    gnt_idx;
  logic                    last_grant;
  logic                    issuing;
  logic                    rsp_take;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    cmd_valid_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [SIZE_WIDTH-1:0]   cmd_size_q;
  array_struct_type        cmd_struct_q;
  logic                    drained_q;

  round_robin_priority_arbiter_2x1 u_rr (
    .valid      (buf_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign gnt_idx = grant[1];
  assign load    = bus.req_valid_in & ready_q;

  // Flushing continues in ARB_DRAIN so the unit can quiesce.
  assign issuing = (state == ARB_RUN ||
                    state == ARB_DRAIN) &&
                   (|buf_valid) &&
                   bus.cmd_ready_in &&
                   (credits != '0);

  // A response with every credit home has no matching read.
  assign rsp_take = bus.rsp_done_in &&
                    (credits != CRED_FULL);

  // Ready cannot overlap a held entry, so grant and load never collide.
  always_comb begin
    buf_valid_nxt = buf_valid;
    for (int i = 0; i < 2; i++) begin
      if (issuing && grant[i])
        buf_valid_nxt[i] = 1'b0;
      else if (load[i])
        buf_valid_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      buf_valid <= 2'b00;
      ready_q   <= 2'b11;
      for (int i = 0; i < 2; i++) begin
        buf_addr[i] <= '0;
        buf_size[i] <= '0;
      end
    end else begin
      buf_valid <= buf_valid_nxt;
      ready_q   <= ~buf_valid_nxt;
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          buf_addr[i] <= bus.req_address_in[i];
          buf_size[i] <= bus.req_size_in[i];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_size_q   <= '0;
      cmd_struct_q <= STRUCT_INVALID;
      last_grant   <= 1'b1;
    end else begin
      cmd_valid_q <= issuing;
      if (issuing) begin
        cmd_addr_q   <= buf_addr[gnt_idx];
        cmd_size_q   <= buf_size[gnt_idx];
        cmd_struct_q <= struct_of(gnt_idx);
        last_grant   <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      credits <= CRED_FULL;
    end else begin
      unique case ({issuing, rsp_take})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state     <= ARB_RESET;
      drained_q <= 1'b0;
    end else begin
      unique case (state)
        ARB_RESET: state <= ARB_IDLE;
        ARB_IDLE: begin
          if (bus.enable_in) begin
            state     <= ARB_RUN;
            drained_q <= 1'b0;
          end
        end
        ARB_RUN: begin
          if (!bus.enable_in)
            state <= ARB_DRAIN;
        end
        ARB_DRAIN: begin
          if (bus.enable_in) begin
            state <= ARB_RUN;
          end else if (buf_valid == 2'b00 &&
                       credits == CRED_FULL) begin
            state     <= ARB_IDLE;
            drained_q <= 1'b1;
          end
        end
        default: state <= ARB_RESET;
      endcase
    end
  end

  assign bus.req_ready_out   = ready_q;
  assign bus.cmd_valid_out   = cmd_valid_q;
  assign bus.cmd_address_out = cmd_addr_q;
  assign bus.cmd_size_out    = cmd_size_q;
  assign bus.cmd_struct_out  = cmd_struct_q;
  assign bus.credits_out     = credits;
  assign bus.drained_out     = drained_q;

  a_rsp_overflow: assert property (
    @(posedge clock) disable iff (!rstn)
    !(bus.rsp_done_in && credits == CRED_FULL)
  );

endmodule

// File: tb/tb_read_command_arbiter_rr.sv
// Self-checking bench for read_command_arbiter_rr: directed scenarios
// plus a randomized run against a transaction-level reference model.
module tb_read_command_arbiter_rr;
  import read_command_arbiter_rr_pkg::*;

  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int checks   = 0;
  int failures = 0;

  read_command_arbiter_rr_if bus ();

  read_command_arbiter_rr dut (
    .clock (clock),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable_in    = 1'b0;
    bus.req_valid_in = 2'b00;
    bus.cmd_ready_in = 1'b1;
    bus.rsp_done_in  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req_address_in[i] = '0;
      bus.req_size_in[i]    = '0;
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clock);
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
  endtask

  // RESET -> IDLE on the first edge, IDLE -> RUN on the second.
  task automatic go_run();
    bus.enable_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.req_ready_out !== 2'b11) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=11",
               bus.req_ready_out);
    end
    checks++;
    if (bus.cmd_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd_valid got=%b exp=0",
               bus.cmd_valid_out);
    end
    checks++;
    if (bus.cmd_struct_out !== STRUCT_INVALID) begin
      failures++;
      $display("FAIL reset_struct got=%0d exp=%0d",
               bus.cmd_struct_out, STRUCT_INVALID);
    end
    checks++;
    if (bus.cmd_address_out !== 64'h0 ||
        bus.cmd_size_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr_size got=%0h/%0h exp=0/0",
               bus.cmd_address_out, bus.cmd_size_out);
    end
    checks++;
    if (bus.credits_out !== 5'd16) begin
      failures++;
      $display("FAIL reset_credits got=%0d exp=16",
               bus.credits_out);
    end
    checks++;
    if (bus.drained_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_drained got=%b exp=0",
               bus.drained_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    go_run();
    bus.req_valid_in      = 2'b01;
    bus.req_address_in[0] = 64'h1000;
    bus.req_size_in[0]    = 32'd64;
    tick();
    bus.req_valid_in = 2'b00;
    checks++;
    if (bus.cmd_valid_out !== 1'b0 ||
        bus.req_ready_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL single_accept got=v%b r%b exp=v0 r0",
               bus.cmd_valid_out, bus.req_ready_out[0]);
    end
    tick();
    checks++;
    if (bus.cmd_valid_out !== 1'b1 ||
        bus.cmd_address_out !== 64'h1000 ||
        bus.cmd_size_out !== 32'd64) begin
      failures++;
      $display("FAIL single_cmd got=v%b a%0h s%0d exp=v1 a1000 s64",
               bus.cmd_valid_out, bus.cmd_address_out,
               bus.cmd_size_out);
    end
    checks++;
    if (bus.cmd_struct_out !== INV_EDGE_ARRAY_DEST) begin
      failures++;
      $display("FAIL single_struct got=%0d exp=%0d",
               bus.cmd_struct_out, INV_EDGE_ARRAY_DEST);
    end
    checks++;
    if (bus.credits_out !== 5'd15) begin
      failures++;
      $display("FAIL single_credits got=%0d exp=15",
               bus.credits_out);
    end
    tick();
    checks++;
    if (bus.cmd_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL single_pulse got=%b exp=0",
               bus.cmd_valid_out);
    end
    bus.rsp_done_in = 1'b1;
    tick();
    bus.rsp_done_in = 1'b0;
    checks++;
    if (bus.credits_out !== 5'd16) begin
      failures++;
      $display("FAIL single_return got=%0d exp=16",
               bus.credits_out);
    end
  endtask

  task automatic test_contention();
    array_struct_type exp_s;
    logic [63:0] exp_a;
    do_reset();
    go_run();
    bus.req_address_in[0] = 64'h100;
    bus.req_address_in[1] = 64'h200;
    bus.req_valid_in      = 2'b11;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      exp_s = (k % 2 == 0) ? INV_EDGE_ARRAY_DEST
                           : READ_GRAPH_DATA;
      exp_a = (k % 2 == 0) ? 64'h100 : 64'h200;
      checks++;
      if (bus.cmd_valid_out !== 1'b1 ||
          bus.cmd_struct_out !== exp_s ||
          bus.cmd_address_out !== exp_a) begin
        failures++;
        $display("FAIL contention_%0d got=v%b s%0d a%0h exp=v1 s%0d a%0h",
                 k, bus.cmd_valid_out, bus.cmd_struct_out,
                 bus.cmd_address_out, exp_s, exp_a);
      end
    end
    bus.req_valid_in = 2'b00;
    bus.cmd_ready_in = 1'b0;
    tick();
    checks++;
    if (bus.credits_out !== 5'd8 ||
        bus.cmd_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL contention_credits got=%0d v%b exp=8 v0",
               bus.credits_out, bus.cmd_valid_out);
    end
  endtask

  task automatic test_credit_exhaust();
    int n;
    do_reset();
    go_run();
    bus.req_valid_in = 2'b11;
    n = 0;
    repeat (30) begin
      tick();
      if (bus.cmd_valid_out) n++;
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL exhaust_count got=%0d exp=16", n);
    end
    checks++;
    if (bus.credits_out !== 5'd0 ||
        bus.req_ready_out !== 2'b00) begin
      failures++;
      $display("FAIL exhaust_state got=c%0d r%b exp=c0 r00",
               bus.credits_out, bus.req_ready_out);
    end
    bus.rsp_done_in = 1'b1;
    tick();
    bus.rsp_done_in = 1'b0;
    n = bus.cmd_valid_out ? 1 : 0;
    repeat (6) begin
      tick();
      if (bus.cmd_valid_out) n++;
    end
    checks++;
    if (n != 1 || bus.credits_out !== 5'd0) begin
      failures++;
      $display("FAIL exhaust_one_more got=n%0d c%0d exp=n1 c0",
               n, bus.credits_out);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    go_run();
    bus.req_address_in[0] = 64'hB0;
    bus.req_address_in[1] = 64'hB1;
    bus.cmd_ready_in      = 1'b0;
    bus.req_valid_in      = 2'b11;
    tick();
    bus.req_valid_in = 2'b00;
    n = 0;
    repeat (5) begin
      tick();
      if (bus.cmd_valid_out) n++;
    end
    checks++;
    if (n != 0 || bus.req_ready_out !== 2'b00 ||
        bus.credits_out !== 5'd16) begin
      failures++;
      $display("FAIL bp_hold got=n%0d r%b c%0d exp=n0 r00 c16",
               n, bus.req_ready_out, bus.credits_out);
    end
    bus.cmd_ready_in = 1'b1;
    tick();
    checks++;
    if (bus.cmd_valid_out !== 1'b1 ||
        bus.cmd_address_out !== 64'hB0 ||
        bus.credits_out !== 5'd15) begin
      failures++;
      $display("FAIL bp_release got=v%b a%0h c%0d exp=v1 aB0 c15",
               bus.cmd_valid_out, bus.cmd_address_out,
               bus.credits_out);
    end
    bus.rsp_done_in = 1'b1;
    tick();
    bus.rsp_done_in = 1'b0;
    checks++;
    if (bus.cmd_valid_out !== 1'b1 ||
        bus.cmd_struct_out !== READ_GRAPH_DATA ||
        bus.credits_out !== 5'd15) begin
      failures++;
      $display("FAIL bp_simul got=v%b s%0d c%0d exp=v1 s%0d c15",
               bus.cmd_valid_out, bus.cmd_struct_out,
               bus.credits_out, READ_GRAPH_DATA);
    end
  endtask

  task automatic test_drain();
    do_reset();
    go_run();
    for (int k = 0; k < 3; k++) begin
      bus.req_address_in[0] = 64'hC0 + 64'(k);
      bus.req_valid_in      = 2'b01;
      tick();
      bus.req_valid_in = 2'b00;
      tick();
    end
    checks++;
    if (bus.credits_out !== 5'd13) begin
      failures++;
      $display("FAIL drain_outstanding got=%0d exp=13",
               bus.credits_out);
    end
    bus.cmd_ready_in      = 1'b0;
    bus.req_address_in[1] = 64'hD0;
    bus.req_valid_in      = 2'b10;
    tick();
    bus.req_valid_in = 2'b00;
    bus.enable_in    = 1'b0;
    tick();
    bus.cmd_ready_in = 1'b1;
    tick();
    checks++;
    if (bus.cmd_valid_out !== 1'b1 ||
        bus.cmd_address_out !== 64'hD0 ||
        bus.credits_out !== 5'd12) begin
      failures++;
      $display("FAIL drain_flush got=v%b a%0h c%0d exp=v1 aD0 c12",
               bus.cmd_valid_out, bus.cmd_address_out,
               bus.credits_out);
    end
    bus.rsp_done_in = 1'b1;
    repeat (4) tick();
    bus.rsp_done_in = 1'b0;
    checks++;
    if (bus.drained_out !== 1'b0 ||
        bus.credits_out !== 5'd16) begin
      failures++;
      $display("FAIL drain_early got=d%b c%0d exp=d0 c16",
               bus.drained_out, bus.credits_out);
    end
    tick();
    checks++;
    if (bus.drained_out !== 1'b1) begin
      failures++;
      $display("FAIL drain_rise got=%b exp=1",
               bus.drained_out);
    end
    bus.enable_in = 1'b1;
    tick();
    checks++;
    if (bus.drained_out !== 1'b0) begin
      failures++;
      $display("FAIL drain_clear got=%b exp=0",
               bus.drained_out);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    go_run();
    bus.req_valid_in = 2'b11;
    repeat (4) tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.cmd_valid_out !== 1'b0 ||
        bus.credits_out !== 5'd16 ||
        bus.req_ready_out !== 2'b11 ||
        bus.cmd_struct_out !== STRUCT_INVALID) begin
      failures++;
      $display("FAIL async_reset got=v%b c%0d r%b s%0d exp=v0 c16 r11 s%0d",
               bus.cmd_valid_out, bus.credits_out,
               bus.req_ready_out, bus.cmd_struct_out,
               STRUCT_INVALID);
    end
    @(negedge clock);
    rstn  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (bus.cmd_valid_out) begin
        found = 1'b1;
        checks++;
        if (bus.cmd_struct_out !== INV_EDGE_ARRAY_DEST) begin
          failures++;
          $display("FAIL async_first_grant got=%0d exp=%0d",
                   bus.cmd_struct_out, INV_EDGE_ARRAY_DEST);
        end
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL async_restart got=no_issue exp=issue_within_10");
    end
  endtask

  // Model: one pending slot per requester, an integer credit pool and
  // the index of the last winner; each cycle at most one command leaves.
  task automatic test_random();
    bit          m_pend [2];
    logic [63:0] m_addr [2];
    logic [31:0] m_size [2];
    int          m_credits;
    int          m_last;
    bit          acc [2];
    bit          e_valid;
    logic [63:0] e_addr;
    logic [31:0] e_size;
    array_struct_type e_struct;
    logic [1:0]  e_ready;
    int          pick;
    do_reset();
    go_run();
    m_pend[0] = 0;
    m_pend[1] = 0;
    m_credits = 16;
    m_last    = 1;
    e_addr    = '0;
    e_size    = '0;
    e_struct  = STRUCT_INVALID;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.req_valid_in = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        bus.req_address_in[i] = {$urandom, $urandom};
        bus.req_size_in[i]    = $urandom;
      end
      bus.cmd_ready_in = ($urandom % 4) != 0;
      bus.rsp_done_in  = (m_credits < 16) &&
                         ($urandom % 3 == 0);
      for (int i = 0; i < 2; i++)
        acc[i] = bus.req_valid_in[i] && !m_pend[i];
      e_valid = (m_credits > 0) && bus.cmd_ready_in &&
                (m_pend[0] || m_pend[1]);
      if (e_valid) begin
        pick = (m_last + 1) % 2;
        if (!m_pend[pick]) pick = 1 - pick;
        e_addr   = m_addr[pick];
        e_size   = m_size[pick];
        e_struct = (pick == 0) ? INV_EDGE_ARRAY_DEST
                               : READ_GRAPH_DATA;
        m_pend[pick] = 0;
        m_last       = pick;
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          m_pend[i] = 1;
          m_addr[i] = bus.req_address_in[i];
          m_size[i] = bus.req_size_in[i];
        end
      end
      m_credits = m_credits + (bus.rsp_done_in ? 1 : 0)
                            - (e_valid ? 1 : 0);
      e_ready = {~m_pend[1], ~m_pend[0]};
      tick();
      checks++;
      if (bus.cmd_valid_out !== e_valid) begin
        failures++;
        $display("FAIL rnd_valid cyc=%0d got=%b exp=%b",
                 cyc, bus.cmd_valid_out, e_valid);
      end
      if (e_valid) begin
        checks++;
        if (bus.cmd_address_out !== e_addr ||
            bus.cmd_size_out !== e_size ||
            bus.cmd_struct_out !== e_struct) begin
          failures++;
          $display("FAIL rnd_cmd cyc=%0d got=%0h/%0h/%0d exp=%0h/%0h/%0d",
                   cyc, bus.cmd_address_out, bus.cmd_size_out,
                   bus.cmd_struct_out, e_addr, e_size, e_struct);
        end
      end
      checks++;
      if (bus.credits_out !== 5'(m_credits)) begin
        failures++;
        $display("FAIL rnd_credits cyc=%0d got=%0d exp=%0d",
                 cyc, bus.credits_out, m_credits);
      end
      checks++;
      if (bus.req_ready_out !== e_ready) begin
        failures++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b",
                 cyc, bus.req_ready_out, e_ready);
      end
    end
    bus.req_valid_in = 2'b00;
    bus.rsp_done_in  = 1'b0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_credit_exhaust();
    test_backpressure();
    test_drain();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
